wb_write_arbiter: RTL and testbench

- Writer-side counterpart of the CPU register file.
- Merges the three writeback sources into the register file's single write port (rf_rd, rf_indata, rf_we):
  - ALU: single-cycle, cannot stall.
  - LSU load return: valid/ready handshake.
  - MDU (multiply/divide) result: valid/ready handshake.
- Keeps a pending-write scoreboard for LSU/MDU destinations so decode can stall on RAW hazards.
- Sits between the execute/memory stages and the register file.

---
 rtl/wb_write_arbiter_pkg.sv | 13 +
 rtl/wb_write_arbiter_if.sv | 45 ++++
 rtl/wb_scoreboard.sv | 35 +++
 rtl/wb_write_arbiter.sv | 89 ++++++++
 tb/tb_wb_write_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared CPU writeback constants and the source-select encoding.
package wb_write_arbiter_pkg;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2,
    SRC_MDU  = 2'd3
  } src_e;
endpackage

// File: rtl/wb_write_arbiter_if.sv
// Writeback bus: three sources, decode hazard query and register-file write port.
interface wb_write_arbiter_if
  import wb_write_arbiter_pkg::*;
#(
  parameter int DW   = wb_write_arbiter_pkg::DW,
  parameter int AW   = wb_write_arbiter_pkg::AW,
  parameter int NREG = wb_write_arbiter_pkg::NREG
) ();
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [DW-1:0]   alu_data;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [DW-1:0]   lsu_data;
  logic            lsu_ready;
  logic            mdu_valid;
  logic [AW-1:0]   mdu_rd;
  logic [DW-1:0]   mdu_data;
  logic            mdu_ready;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            stall;
  logic [AW-1:0]   rf_rd;
  logic [DW-1:0]   rf_indata;
  logic            rf_we;
  logic [NREG-1:0] pending;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data, input lsu_ready,
    output mdu_valid, mdu_rd, mdu_data, input mdu_ready,
    output iss_valid, iss_rd, rs1, rs2, input stall,
    input  rf_rd, rf_indata, rf_we, pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data, output lsu_ready,
    input  mdu_valid, mdu_rd, mdu_data, output mdu_ready,
    input  iss_valid, iss_rd, rs1, rs2, output stall,
    output rf_rd, rf_indata, rf_we, pending
  );
endinterface

// File: rtl/wb_scoreboard.sv
// Pending-write scoreboard for multi-cycle ops plus the decode RAW stall compare.
module wb_scoreboard
  import wb_write_arbiter_pkg::*;
#(
  parameter int AW   = wb_write_arbiter_pkg::AW,
  parameter int NREG = wb_write_arbiter_pkg::NREG
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            set_en_i,
  input  logic [AW-1:0]   set_rd_i,
  input  logic            clr_en_i,
  input  logic [AW-1:0]   clr_rd_i,
  input  logic [AW-1:0]   rs1_i,
  input  logic [AW-1:0]   rs2_i,
  output logic [NREG-1:0] pending_o,
  output logic            stall_o
);
  logic [NREG-1:0] pend_q, pend_d;

  // Set is applied after clear so a re-issue to the same register keeps it claimed.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_rd_i] = 1'b0;
    if (set_en_i && set_rd_i != '0) pend_d[set_rd_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  assign pending_o = pend_q;
  assign stall_o   = (rs1_i != '0 && pend_q[rs1_i]) || (rs2_i != '0 && pend_q[rs2_i]);
endmodule

// File: rtl/wb_write_arbiter.sv
// Merges ALU, LSU and MDU writebacks onto the single register-file write port.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DW   = wb_write_arbiter_pkg::DW,
  parameter int AW   = wb_write_arbiter_pkg::AW,
  parameter int NREG = wb_write_arbiter_pkg::NREG
) (
  input  logic                 clk,
  input  logic                 rst_n,
  wb_write_arbiter_if.slave    bus
);
  src_e          sel;
  logic [AW-1:0] win_rd;
  logic [DW-1:0] win_data;
  logic          last_lsu_q, last_lsu_d;
  logic [AW-1:0] rf_rd_q, rf_rd_d;
  logic [DW-1:0] rf_data_q, rf_data_d;
  logic          rf_we_q, rf_we_d;
  logic          mc_grant;

  // ALU first; LSU/MDU alternate when both wait. last_lsu_q=0 after reset favours LSU.
  always_comb begin
    sel = SRC_NONE;
    if (bus.alu_valid)                      sel = SRC_ALU;
    else if (bus.lsu_valid && bus.mdu_valid) sel = last_lsu_q ? SRC_MDU : SRC_LSU;
    else if (bus.lsu_valid)                 sel = SRC_LSU;
    else if (bus.mdu_valid)                 sel = SRC_MDU;
  end

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    case (sel)
      SRC_ALU: begin win_rd = bus.alu_rd; win_data = bus.alu_data; end
      SRC_LSU: begin win_rd = bus.lsu_rd; win_data = bus.lsu_data; end
      SRC_MDU: begin win_rd = bus.mdu_rd; win_data = bus.mdu_data; end
      default: ;
    endcase
  end

  assign mc_grant      = (sel == SRC_LSU) || (sel == SRC_MDU);
  assign bus.lsu_ready = (sel == SRC_LSU);
  assign bus.mdu_ready = (sel == SRC_MDU);

  always_comb begin
    last_lsu_d = last_lsu_q;
    rf_rd_d    = rf_rd_q;
    rf_data_d  = rf_data_q;
    rf_we_d    = 1'b0;
    if (mc_grant) last_lsu_d = (sel == SRC_LSU);
    if (sel != SRC_NONE) begin
      rf_rd_d   = win_rd;
      rf_data_d = win_data;
      rf_we_d   = (win_rd != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_lsu_q <= 1'b0;
      rf_rd_q    <= '0;
      rf_data_q  <= '0;
      rf_we_q    <= 1'b0;
    end else begin
      last_lsu_q <= last_lsu_d;
      rf_rd_q    <= rf_rd_d;
      rf_data_q  <= rf_data_d;
      rf_we_q    <= rf_we_d;
    end
  end

  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_indata = rf_data_q;
  assign bus.rf_we     = rf_we_q;

  wb_scoreboard #(.AW(AW), .NREG(NREG)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_en_i  (bus.iss_valid),
    .set_rd_i  (bus.iss_rd),
    .clr_en_i  (mc_grant),
    .clr_rd_i  (win_rd),
    .rs1_i     (bus.rs1),
    .rs2_i     (bus.rs2),
    .pending_o (bus.pending),
    .stall_o   (bus.stall)
  );
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed plus randomized check of the writeback arbiter against a queue-free behavioural model.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_write_arbiter_if bus ();
  wb_write_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_fail = 0;

  // model state
  logic [NREG-1:0] m_pend;
  string           m_pref;   // which multi-cycle source wins a tie next
  logic [AW-1:0]   m_rd;
  logic [DW-1:0]   m_data;
  logic            m_we;
  string           last_win;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_pref = "lsu"; m_rd = '0; m_data = '0; m_we = 1'b0; last_win = "none";
  endtask

  function automatic string winner();
    if (bus.alu_valid) return "alu";
    if (bus.lsu_valid && bus.mdu_valid) return m_pref;
    if (bus.lsu_valid) return "lsu";
    if (bus.mdu_valid) return "mdu";
    return "none";
  endfunction

  function automatic bit m_stall(logic [AW-1:0] a, logic [AW-1:0] b);
    return (a != 0 && m_pend[a]) || (b != 0 && m_pend[b]);
  endfunction

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic step();
    string w;
    logic [AW-1:0] rd;
    logic [DW-1:0] d;
    #1;
    w = winner();
    chk("lsu_ready", bus.lsu_ready, w == "lsu");
    chk("mdu_ready", bus.mdu_ready, w == "mdu");
    chk("stall", bus.stall, m_stall(bus.rs1, bus.rs2));
    if (bus.alu_valid) chk("alu_to_pending", bus.pending[bus.alu_rd], 0);
    rd = (w == "alu") ? bus.alu_rd : (w == "lsu") ? bus.lsu_rd : bus.mdu_rd;
    d  = (w == "alu") ? bus.alu_data : (w == "lsu") ? bus.lsu_data : bus.mdu_data;
    m_we = 1'b0;
    if (w != "none") begin
      m_rd = rd; m_data = d; m_we = (rd != 0);
    end
    if (w == "lsu" || w == "mdu") begin
      m_pend[rd] = 1'b0;
      m_pref = (w == "lsu") ? "mdu" : "lsu";
    end
    if (bus.iss_valid && bus.iss_rd != 0) m_pend[bus.iss_rd] = 1'b1;
    last_win = w;
    @(posedge clk); #1;
    chk("rf_we", bus.rf_we, m_we);
    chk("rf_rd", bus.rf_rd, m_rd);
    chk("rf_indata", bus.rf_indata, m_data);
    chk("pending", bus.pending, m_pend);
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.lsu_valid = 0; bus.mdu_valid = 0; bus.iss_valid = 0;
  endtask

  function automatic logic [AW-1:0] free_rd();
    logic [AW-1:0] r;
    r = AW'($urandom_range(0, NREG - 1));
    while (r != 0 && m_pend[r]) r = r + 1'b1;
    return r;
  endfunction

  initial begin
    model_reset();
    idle();
    bus.alu_rd = 0; bus.alu_data = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
    bus.mdu_rd = 0; bus.mdu_data = 0; bus.iss_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("reset_we", bus.rf_we, 0);
    chk("reset_pending", bus.pending, 0);

    // reset mid-stream with ALU traffic and a pending entry
    bus.iss_valid = 1; bus.iss_rd = 6; step();
    bus.iss_valid = 0; bus.alu_valid = 1; bus.alu_rd = 2; bus.alu_data = 32'h55; step();
    #2 rst_n = 1'b0; #1;
    model_reset();
    chk("rst_async_we", bus.rf_we, 0);
    chk("rst_async_pend", bus.pending, 0);
    @(posedge clk); #1;
    chk("rst_hold_we", bus.rf_we, 0);
    @(negedge clk); rst_n = 1'b1;
    bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
    step();
    chk("post_rst_we", bus.rf_we, 1);
    chk("post_rst_rd", bus.rf_rd, 5);
    chk("post_rst_data", bus.rf_indata, 32'hDEADBEEF);

    // priority: ALU blocks both others
    bus.lsu_valid = 1; bus.lsu_rd = 3; bus.lsu_data = 32'h333;
    bus.mdu_valid = 1; bus.mdu_rd = 4; bus.mdu_data = 32'h444;
    for (int i = 0; i < 3; i++) begin
      bus.alu_rd = AW'(10 + i); bus.alu_data = 32'hA0 + i; step();
    end
    bus.alu_valid = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_order", (last_win == ((i % 2 == 0) ? "lsu" : "mdu")), 1);
    end

    // scoreboard set then clear by LSU return
    idle(); bus.iss_valid = 1; bus.iss_rd = 7; bus.rs1 = 7; step();
    bus.iss_valid = 0; step();
    chk("stall_set", bus.stall, 1);
    bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_data = 32'h1234; step();
    chk("stall_clr", bus.stall, 0);
    chk("clr_write", {bus.rf_we, bus.rf_rd, bus.rf_indata}, {1'b1, 5'd7, 32'h1234});

    // set/clear collision on the same register
    idle(); bus.iss_valid = 1; bus.iss_rd = 9; bus.rs1 = 9; step();
    bus.mdu_valid = 1; bus.mdu_rd = 9; bus.mdu_data = 32'h99; step();
    chk("collide_pend9", bus.pending[9], 1);
    chk("collide_stall", bus.stall, 1);

    // x0 handling
    idle(); bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_data = 32'hBAD; step();
    chk("x0_we", bus.rf_we, 0);
    idle(); bus.iss_valid = 1; bus.iss_rd = 0; bus.rs1 = 0; bus.rs2 = 0; step();
    chk("x0_nostall", bus.stall, 0);

    // backpressure: MDU waits behind 5 ALU cycles
    idle(); bus.mdu_valid = 1; bus.mdu_rd = 12; bus.mdu_data = 32'hC0FFEE; bus.alu_valid = 1;
    for (int i = 0; i < 5; i++) begin
      bus.alu_rd = free_rd(); bus.alu_data = $urandom; step();
    end
    bus.alu_valid = 0; step();
    chk("bp_accept", (last_win == "mdu"), 1);
    chk("bp_write", {bus.rf_we, bus.rf_rd, bus.rf_indata}, {1'b1, 5'd12, 32'hC0FFEE});

    // randomized traffic; stalled sources hold their payload
    idle();
    for (int i = 0; i < 400; i++) begin
      if (!(bus.lsu_valid && last_win != "lsu")) begin
        bus.lsu_valid = ($urandom_range(0, 9) < 4);
        bus.lsu_rd = AW'($urandom); bus.lsu_data = $urandom;
      end
      if (!(bus.mdu_valid && last_win != "mdu")) begin
        bus.mdu_valid = ($urandom_range(0, 9) < 4);
        bus.mdu_rd = AW'($urandom); bus.mdu_data = $urandom;
      end
      bus.alu_valid = ($urandom_range(0, 9) < 4);
      bus.alu_rd = free_rd(); bus.alu_data = $urandom;
      bus.iss_valid = ($urandom_range(0, 9) < 3);
      bus.iss_rd = AW'($urandom);
      bus.rs1 = AW'($urandom); bus.rs2 = AW'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
